// File: rtl/keypad_pkg.sv
// keypad_pkg: types and constants shared by the keypad scanner files.
//   state_t        - scanner FSM states
//   KEY_MAP        - 16-entry key code table, indexed by {row, col}
//   KEY_STAR/HASH  - codes of the '*' and '#' keys
//   lowest_low_row - index of the lowest-numbered active-low row
//   col_drive      - active-low one-cold column pattern for a column index
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Packed entry 15 is the leftmost one: row3/col3 first, row0/col0 last.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,   // row 3: col3..col0
        4'hC, 4'h9,     4'h8, 4'h7,       // row 2
        4'hB, 4'h6,     4'h5, 4'h4,       // row 1
        4'hA, 4'h3,     4'h2, 4'h1        // row 0
    };

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: free-running column slot counter (0..SCAN_TICKS-1, wrapping)
// and the sample strobe, high for the one cycle the count sits at its last value.
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   sample - 1-cycle sample strobe
module keypad_tick #(
    parameter int unsigned SCAN_TICKS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample
);

    localparam int unsigned CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);

    logic [CW-1:0] count_r;

    // Slot counter; wraps at the sample point so every state change starts a fresh slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (count_r == LAST) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign sample = (count_r == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press and release debounce.
//   clk       - clock, all state on the rising edge
//   rst_n     - asynchronous active-low reset
//   row_in    - keypad rows, active-low, asynchronous
//   col_out   - column drive, active-low, exactly one bit low
//   key_code  - code of the last accepted key (held)
//   key_valid - 1-cycle pulse when a new key is accepted
//   key_held  - high while the accepted key stays pressed
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS   = 50000,
    parameter int unsigned DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DONE = DW'(DEBOUNCE_CNT);
    localparam logic ONE_SHOT = (DEBOUNCE_CNT <= 1) ? 1'b1 : 1'b0;

    state_t        state_r, state_nxt;
    logic [3:0]    row_meta_r, row_sync_r;
    logic [1:0]    col_r, col_nxt;
    logic [1:0]    row_r, row_nxt;
    logic [DW-1:0] match_r, match_nxt;
    logic [3:0]    col_out_r, key_code_r, code_nxt;
    logic          key_valid_r, valid_nxt;
    logic          key_held_r, held_nxt;
    // After a release the keypad must read idle on every column for a full
    // rotation before a new press is accepted; a second key still held from
    // a chord therefore never gets accepted.
    logic          armed_r, armed_nxt;
    logic [1:0]    clean_r, clean_nxt;

    logic          sample_s;
    logic          all_high_s;
    logic [1:0]    low_row_s;
    logic [DW-1:0] match_inc_s;

    keypad_tick #(.SCAN_TICKS(SCAN_TICKS)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sample_s)
    );

    assign all_high_s  = (row_sync_r == 4'hF);
    assign low_row_s   = lowest_low_row(row_sync_r);
    assign match_inc_s = match_r + DW'(1);

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Next-state and output decode; every change happens on a sample strobe.
    always_comb begin
        state_nxt = state_r;
        col_nxt   = col_r;
        row_nxt   = row_r;
        match_nxt = match_r;
        code_nxt  = key_code_r;
        valid_nxt = 1'b0;
        held_nxt  = key_held_r;
        armed_nxt = armed_r;
        clean_nxt = clean_r;
        case (state_r)
            SCAN: begin
                if (!sample_s) begin
                    state_nxt = SCAN;
                end else if (!armed_r) begin
                    col_nxt = col_r + 2'd1;
                    if (all_high_s) begin
                        clean_nxt = clean_r + 2'd1;
                        armed_nxt = (clean_r == 2'd3) ? 1'b1 : 1'b0;
                    end else begin
                        clean_nxt = 2'd0;
                    end
                end else if (!all_high_s) begin
                    row_nxt   = low_row_s;
                    match_nxt = DW'(1);
                    if (ONE_SHOT) begin
                        code_nxt  = KEY_MAP[{low_row_s, col_r}];
                        valid_nxt = 1'b1;
                        held_nxt  = 1'b1;
                        state_nxt = PRESSED;
                    end else begin
                        state_nxt = DEB_PRESS;
                    end
                end else begin
                    col_nxt = col_r + 2'd1;
                end
            end
            DEB_PRESS: begin
                if (!sample_s) begin
                    state_nxt = DEB_PRESS;
                end else if (!all_high_s && (low_row_s == row_r)) begin
                    match_nxt = match_inc_s;
                    if (match_inc_s == DONE) begin
                        code_nxt  = KEY_MAP[{row_r, col_r}];
                        valid_nxt = 1'b1;
                        held_nxt  = 1'b1;
                        state_nxt = PRESSED;
                    end else begin
                        state_nxt = DEB_PRESS;
                    end
                end else begin
                    match_nxt = {DW{1'b0}};
                    col_nxt   = col_r + 2'd1;
                    state_nxt = SCAN;
                end
            end
            PRESSED: begin
                if (sample_s && all_high_s) begin
                    match_nxt = DW'(1);
                    if (ONE_SHOT) begin
                        held_nxt  = 1'b0;
                        col_nxt   = col_r + 2'd1;
                        armed_nxt = 1'b0;
                        clean_nxt = 2'd0;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = DEB_REL;
                    end
                end else begin
                    state_nxt = PRESSED;
                end
            end
            DEB_REL: begin
                if (!sample_s) begin
                    state_nxt = DEB_REL;
                end else if (all_high_s) begin
                    match_nxt = match_inc_s;
                    if (match_inc_s == DONE) begin
                        match_nxt = {DW{1'b0}};
                        held_nxt  = 1'b0;
                        col_nxt   = col_r + 2'd1;
                        armed_nxt = 1'b0;
                        clean_nxt = 2'd0;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = DEB_REL;
                    end
                end else begin
                    // Release bounce: the key is still down, no new key_valid.
                    match_nxt = {DW{1'b0}};
                    state_nxt = PRESSED;
                end
            end
            default: begin
                state_nxt = SCAN;
                match_nxt = {DW{1'b0}};
                held_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SCAN;
            col_r       <= 2'd0;
            row_r       <= 2'd0;
            match_r     <= {DW{1'b0}};
            col_out_r   <= 4'b1110;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            armed_r     <= 1'b1;
            clean_r     <= 2'd0;
        end else begin
            state_r     <= state_nxt;
            col_r       <= col_nxt;
            row_r       <= row_nxt;
            match_r     <= match_nxt;
            col_out_r   <= col_drive(col_nxt);
            key_code_r  <= code_nxt;
            key_valid_r <= valid_nxt;
            key_held_r  <= held_nxt;
            armed_r     <= armed_nxt;
            clean_r     <= clean_nxt;
        end
    end

    assign col_out   = col_out_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 50000, meaning clk cycles per column slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 16, meaning consecutive matching samples needed to accept a press or a release.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
REQ-006 SHALL have port col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  code of last accepted key, held until the next accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL use a slot counter counting 0..SCAN_TICKS-1 and wrapping; the sample point is count SCAN_TICKS-1.
REQ-012 SHALL have FSM states SCAN, DEB_PRESS, PRESSED, DEB_REL.
REQ-013 In SCAN: col_out rotates 1110->1101->1011->0111->1110, advancing one step after each sample point with no key seen.
REQ-014 In SCAN at a sample point with any row low: latch column index and lowest-index low row, go to DEB_PRESS, freeze col_out, counter restarts at 0.
REQ-015 In DEB_PRESS at each sample point: same row low increments the match count; any other row pattern returns to SCAN with the column advanced.
REQ-016 DEB_PRESS: when the match count reaches DEBOUNCE_CNT (including the initial sample from REQ-014), update key_code, pulse key_valid for exactly 1 cycle, and go to PRESSED.
REQ-017 In PRESSED: key_held=1, col_out frozen; the first sample point with all rows high goes to DEB_REL.
REQ-018 In DEB_REL: DEBOUNCE_CNT consecutive all-high samples go to SCAN (key_held=0, col_out advanced); any low row returns to PRESSED with no new key_valid.
REQ-019 Key map SHALL be (row r, col c) row0: 1,2,3,A; row1: 4,5,6,B; row2: 7,8,9,C; row3: *,0,#,D; codes are digits as value, A..D = 0xA..0xD, * = 0xE, # = 0xF.
REQ-020 Multiple simultaneous keys: the first column in scan order wins, then the lowest row within it; no second key is accepted until full release (DEB_REL complete).
REQ-021 Press-to-key_valid latency SHALL be at most 4*SCAN_TICKS + DEBOUNCE_CNT*SCAN_TICKS + 3 cycles.
REQ-022 key_valid and key_code update in the same cycle; key_code is stable while key_valid=1.

Reset
REQ-023 On rst_n low (asynchronous): state=SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_held=0, counters and synchronizer=0/all-high.
REQ-024 Reset mid-debounce or mid-press SHALL discard the pending key; no key_valid may follow reset release until a full new debounce completes.

Structure
REQ-025 Shared package keypad_pkg SHALL hold the FSM state enum, the 16-entry key code map, and the code constants KEY_STAR=0xE and KEY_HASH=0xF.
REQ-026 Slot counter plus sample-strobe generation SHALL be one sub-module, keypad_tick (output: 1-cycle sample strobe).
REQ-027 key_code output SHALL feed the downstream stopwatch/calculator control unmodified; no BCD or display logic inside this block.

Verification (SCAN_TICKS=4, DEBOUNCE_CNT=3)
REQ-028 Reset then idle rows=1111 -> col_out cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
REQ-029 Hold key "5" (row1 low when col1 driven) clean -> exactly one key_valid, key_code=0x5, key_held=1 until release + 3 all-high samples.
REQ-030 Bounce "#" (row3/col2) toggling every 2 cycles for 10 cycles then stable -> exactly one key_valid with key_code=0xF after stabilisation.
REQ-031 Press "1" and "D" together -> key_code=0x1 only; release "1" while holding "D" -> no new key_valid until both are released.
REQ-032 Assert rst_n=0 during DEB_PRESS of "7" -> all outputs at reset values immediately; no key_valid after release of rst_n unless held a further 3 samples.
REQ-033 Release glitch (one low sample during DEB_REL) -> returns to PRESSED, key_held stays 1, no duplicate key_valid.
